// File: rtl/axi3_wid_tracker.sv
// -----------------------------------------------------------------------------
// axi3_wid_tracker
//
// Supplies the AXI3 WID for each write burst crossing from the BIU to the
// system bus. Accepted AW IDs are queued in order. The head of the queue is
// the WID for the burst currently on W. The queue is popped when the last
// beat of that burst is accepted.
//
// The block gates the handshakes in two ways:
//   - AW is held off while the queue is full.
//   - W is held off until an ID is known. The ID comes from the queue head.
//     With BYPASS_EN=1 it can also come from an AW accepted in the same
//     cycle while the queue is empty.
//
// Handshake semantics (both channels): a transfer happens on a rising edge of
// per_clk when valid and ready are both high. valid never depends on ready on
// the same side. The pass-through gating here is purely combinational, so
// neither channel adds latency. All state changes take effect on the next
// edge.
//
// Ports:
//   per_clk, per_rst       clock; synchronous active-high reset
//   s_awid/s_awvalid/s_awready   AW from/to BIU
//   m_awvalid/m_awready    AW to/from bus
//   s_wvalid/s_wlast/s_wready    W from/to BIU
//   m_wvalid/m_wready/m_wid      W to/from bus, with generated WID
//   outstanding            number of IDs currently queued
//   err_burst              sticky: a burst ran past MAX_BEATS beats
// -----------------------------------------------------------------------------
module axi3_wid_tracker #(
   parameter int ID_W      = 8,
   parameter int DEPTH     = 4,
   parameter int BYPASS_EN = 1,
   parameter int MAX_BEATS = 16
) (
   input  logic                       per_clk,
   input  logic                       per_rst,
   input  logic [ID_W-1:0]            s_awid,
   input  logic                       s_awvalid,
   output logic                       s_awready,
   output logic                       m_awvalid,
   input  logic                       m_awready,
   input  logic                       s_wvalid,
   input  logic                       s_wlast,
   output logic                       s_wready,
   output logic                       m_wvalid,
   input  logic                       m_wready,
   output logic [ID_W-1:0]            m_wid,
   output logic [$clog2(DEPTH+1)-1:0] outstanding,
   output logic                       err_burst
);

   localparam int   PTR_W  = $clog2(DEPTH);
   localparam int   CNT_W  = $clog2(DEPTH+1);
   localparam int   BEAT_W = $clog2(MAX_BEATS+1);
   localparam logic BYP    = (BYPASS_EN != 0);

   logic [ID_W-1:0]   id_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [BEAT_W-1:0] beat_cnt;

   logic full;
   logic empty;
   logic aw_fire;
   logic wid_avail;
   logic w_fire;
   logic bypass_done;
   logic push;
   logic pop;

   // full/empty are decoded from the registered count only. This keeps a
   // pop from opening AW in the same cycle.
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   assign aw_fire   = s_awvalid & m_awready & ~full;
   assign m_awvalid = s_awvalid & ~full;
   assign s_awready = m_awready & ~full;

   // With an empty queue, the only possible source of an ID is an AW being
   // accepted right now, and only when bypass is enabled.
   assign wid_avail = ~empty | (BYP & aw_fire);
   assign m_wvalid  = s_wvalid & wid_avail;
   assign s_wready  = m_wready & wid_avail;
   assign w_fire    = s_wvalid & m_wready & wid_avail;

   assign m_wid = empty ? s_awid : id_mem[rd_ptr];

   // A single-beat burst fully consumed in bypass never enters the queue.
   // For a multi-beat bypass the ID is pushed, so the entry becomes the head
   // for the remaining beats.
   assign bypass_done = empty & aw_fire & w_fire & s_wlast;
   assign push        = aw_fire & ~bypass_done;
   assign pop         = w_fire & s_wlast & ~empty;

   assign outstanding = count;

   // ID storage has no reset. Entries are only read once count covers them.
   always_ff @(posedge per_clk) begin
      if (push) begin
         id_mem[wr_ptr] <= s_awid;
      end
   end

   always_ff @(posedge per_clk) begin
      if (per_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // The beat counter holds the number of beats already sent in the current
   // burst. When the beat that would be beat MAX_BEATS is also not last, the
   // burst is over-long. The counter then saturates, and WID tracking carries
   // on unaffected.
   always_ff @(posedge per_clk) begin
      if (per_rst) begin
         beat_cnt  <= '0;
         err_burst <= 1'b0;
      end else if (w_fire) begin
         if (s_wlast) begin
            beat_cnt <= '0;
         end else begin
            if (beat_cnt == BEAT_W'(MAX_BEATS-1)) begin
               err_burst <= 1'b1;
            end
            if (beat_cnt != BEAT_W'(MAX_BEATS)) begin
               beat_cnt <= beat_cnt + BEAT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_axi3_wid_tracker.sv
// -----------------------------------------------------------------------------
// Bench for axi3_wid_tracker.
//
// dut uses BYPASS_EN=1. dut_nb uses BYPASS_EN=0 and has its own AW/W inputs.
// Both instances share the bus-side readies.
//
// Each accepted AW pushes its ID into exp_q once per expected beat. Every
// accepted W beat pops one entry and compares it with m_wid.
// -----------------------------------------------------------------------------
module tb_axi3_wid_tracker;

   logic       per_clk;
   logic       per_rst;
   logic [7:0] s_awid;
   logic       s_awvalid;
   logic       s_awready;
   logic       m_awvalid;
   logic       m_awready;
   logic       s_wvalid;
   logic       s_wlast;
   logic       s_wready;
   logic       m_wvalid;
   logic       m_wready;
   logic [7:0] m_wid;
   logic [2:0] outstanding;
   logic       err_burst;

   logic [7:0] b_awid;
   logic       b_awvalid;
   logic       b_awready;
   logic       b_m_awvalid;
   logic       b_wvalid;
   logic       b_wlast;
   logic       b_wready;
   logic       b_m_wvalid;
   logic [7:0] b_m_wid;
   logic [2:0] b_outstanding;
   logic       b_err_burst;

   logic [7:0] exp_q[$];
   logic [7:0] exp_id;
   logic [7:0] got;
   int         vectors;
   int         miscompares;

   axi3_wid_tracker #(.ID_W(8), .DEPTH(4), .BYPASS_EN(1), .MAX_BEATS(16)) dut (
      .per_clk(per_clk), .per_rst(per_rst),
      .s_awid(s_awid), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .m_awvalid(m_awvalid), .m_awready(m_awready),
      .s_wvalid(s_wvalid), .s_wlast(s_wlast), .s_wready(s_wready),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wid(m_wid),
      .outstanding(outstanding), .err_burst(err_burst)
   );

   axi3_wid_tracker #(.ID_W(8), .DEPTH(4), .BYPASS_EN(0), .MAX_BEATS(16)) dut_nb (
      .per_clk(per_clk), .per_rst(per_rst),
      .s_awid(b_awid), .s_awvalid(b_awvalid), .s_awready(b_awready),
      .m_awvalid(b_m_awvalid), .m_awready(m_awready),
      .s_wvalid(b_wvalid), .s_wlast(b_wlast), .s_wready(b_wready),
      .m_wvalid(b_m_wvalid), .m_wready(m_wready), .m_wid(b_m_wid),
      .outstanding(b_outstanding), .err_burst(b_err_burst)
   );

   // ---------------- clock / watchdog ----------------
   initial per_clk = 1'b0;
   always #5 per_clk = ~per_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, exp summary before 200000");
      $fatal(1, "watchdog expired");
   end

   // ---------------- driver tasks ----------------
   // Inputs change 1 time unit after a rising edge. Outputs are sampled on
   // the falling edge.
   task automatic tick();
      @(posedge per_clk);
      #1;
   endtask

   task automatic do_aw(input logic [7:0] id, input int beats);
      bit ok;
      ok = 1'b0;
      s_awid    = id;
      s_awvalid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge per_clk);
         if (s_awready) begin
            ok = 1'b1;
            for (int b = 0; b < beats; b++) exp_q.push_back(id);
         end
         tick();
      end
      s_awvalid = 1'b0;
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL aw_accept id=%h: got no s_awready, exp accept within 50 cycles", id);
      end
   endtask

   task automatic send_w(input logic last, output logic [7:0] wid);
      bit ok;
      ok  = 1'b0;
      wid = 'x;
      s_wvalid = 1'b1;
      s_wlast  = last;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge per_clk);
         if (s_wready && m_wvalid) begin
            ok  = 1'b1;
            wid = m_wid;
         end
         tick();
      end
      s_wvalid = 1'b0;
      s_wlast  = 1'b0;
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL w_accept: got no s_wready, exp accept within 50 cycles");
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      per_rst = 1'b1;
      s_awvalid = 1'b0; s_wvalid = 1'b1; s_wlast = 1'b1;
      b_awvalid = 1'b0; b_wvalid = 1'b1; b_wlast = 1'b1;
      tick();
      @(negedge per_clk);
      vectors++;
      if (outstanding !== 3'd0) begin miscompares++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
      vectors++;
      if (err_burst !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", err_burst); end
      vectors++;
      if (m_wvalid !== 1'b0 || b_m_wvalid !== 1'b0) begin miscompares++; $display("FAIL reset_wvalid got %b/%b exp 0/0", m_wvalid, b_m_wvalid); end
      vectors++;
      if (s_awready !== 1'b1 || m_awvalid !== 1'b0) begin miscompares++; $display("FAIL reset_aw got rdy=%b vld=%b exp 1/0", s_awready, m_awvalid); end
      tick();
      per_rst = 1'b0;
      s_wvalid = 1'b0; s_wlast = 1'b0;
      b_wvalid = 1'b0; b_wlast = 1'b0;
      tick();
   endtask

   task automatic test_in_order();
      logic lasts [7];
      lasts = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      do_aw(8'h11, 2);
      do_aw(8'h22, 1);
      do_aw(8'h33, 4);
      @(negedge per_clk);
      vectors++;
      if (outstanding !== 3'd3) begin miscompares++; $display("FAIL in_order_outstanding got %0d exp 3", outstanding); end
      tick();
      for (int i = 0; i < 7; i++) begin
         send_w(lasts[i], got);
         exp_id = exp_q.pop_front();
         vectors++;
         if (got !== exp_id) begin miscompares++; $display("FAIL in_order_wid beat %0d got %h exp %h", i, got, exp_id); end
      end
      @(negedge per_clk);
      vectors++;
      if (outstanding !== 3'd0 || err_burst !== 1'b0) begin
         miscompares++; $display("FAIL in_order_drain got out=%0d err=%b exp 0/0", outstanding, err_burst);
      end
      tick();
   endtask

   task automatic test_backpressure();
      m_awready = 1'b0;
      s_awid = 8'hE1; s_awvalid = 1'b1;
      @(negedge per_clk);
      vectors++;
      if (s_awready !== 1'b0 || m_awvalid !== 1'b1) begin miscompares++; $display("FAIL bp_aw got rdy=%b vld=%b exp 0/1", s_awready, m_awvalid); end
      tick();
      s_awvalid = 1'b0;
      m_awready = 1'b1;
      @(negedge per_clk);
      vectors++;
      if (outstanding !== 3'd0) begin miscompares++; $display("FAIL bp_no_push got %0d exp 0", outstanding); end
      tick();
      do_aw(8'hE1, 1);
      m_wready = 1'b0;
      s_wvalid = 1'b1; s_wlast = 1'b1;
      @(negedge per_clk);
      vectors++;
      if (m_wvalid !== 1'b1 || s_wready !== 1'b0) begin miscompares++; $display("FAIL bp_w got vld=%b rdy=%b exp 1/0", m_wvalid, s_wready); end
      tick();
      s_wvalid = 1'b0; s_wlast = 1'b0;
      m_wready = 1'b1;
      @(negedge per_clk);
      vectors++;
      if (outstanding !== 3'd1) begin miscompares++; $display("FAIL bp_no_pop got %0d exp 1", outstanding); end
      tick();
      send_w(1'b1, got);
      exp_id = exp_q.pop_front();
      vectors++;
      if (got !== exp_id) begin miscompares++; $display("FAIL bp_wid got %h exp %h", got, exp_id); end
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) do_aw(8'hA0 + 8'(i), 1);
      @(negedge per_clk);
      vectors++;
      if (outstanding !== 3'd4) begin miscompares++; $display("FAIL full_outstanding got %0d exp 4", outstanding); end
      tick();
      s_awid = 8'hA4; s_awvalid = 1'b1;
      @(negedge per_clk);
      vectors++;
      if (s_awready !== 1'b0 || m_awvalid !== 1'b0) begin miscompares++; $display("FAIL full_block got rdy=%b vld=%b exp 0/0", s_awready, m_awvalid); end
      tick();
      s_wvalid = 1'b1; s_wlast = 1'b1;
      @(negedge per_clk);
      exp_id = exp_q.pop_front();
      vectors++;
      if (s_wready !== 1'b1 || m_wid !== exp_id) begin miscompares++; $display("FAIL full_pop got rdy=%b wid=%h exp 1/%h", s_wready, m_wid, exp_id); end
      vectors++;
      if (s_awready !== 1'b0) begin miscompares++; $display("FAIL full_pop_cycle_aw got %b exp 0", s_awready); end
      tick();
      s_wvalid = 1'b0; s_wlast = 1'b0;
      @(negedge per_clk);
      vectors++;
      if (s_awready !== 1'b1) begin miscompares++; $display("FAIL full_reopen got %b exp 1", s_awready); end
      else exp_q.push_back(8'hA4);
      tick();
      s_awvalid = 1'b0;
      @(negedge per_clk);
      vectors++;
      if (outstanding !== 3'd4) begin miscompares++; $display("FAIL full_refill got %0d exp 4", outstanding); end
      tick();
      for (int i = 0; i < 4; i++) begin
         send_w(1'b1, got);
         exp_id = exp_q.pop_front();
         vectors++;
         if (got !== exp_id) begin miscompares++; $display("FAIL full_drain %0d got %h exp %h", i, got, exp_id); end
      end
   endtask

   task automatic test_push_pop();
      do_aw(8'h40, 1);
      do_aw(8'h41, 1);
      s_awid = 8'h44; s_awvalid = 1'b1;
      s_wvalid = 1'b1; s_wlast = 1'b1;
      @(negedge per_clk);
      exp_id = exp_q.pop_front();
      exp_q.push_back(8'h44);
      vectors++;
      if (s_awready !== 1'b1 || s_wready !== 1'b1 || m_wid !== exp_id) begin
         miscompares++; $display("FAIL push_pop got ardy=%b wrdy=%b wid=%h exp 1/1/%h", s_awready, s_wready, m_wid, exp_id);
      end
      tick();
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_wlast = 1'b0;
      @(negedge per_clk);
      vectors++;
      if (outstanding !== 3'd2 || m_wid !== exp_q[0]) begin
         miscompares++; $display("FAIL push_pop_after got out=%0d head=%h exp 2/%h", outstanding, m_wid, exp_q[0]);
      end
      tick();
      for (int i = 0; i < 2; i++) begin
         send_w(1'b1, got);
         exp_id = exp_q.pop_front();
         vectors++;
         if (got !== exp_id) begin miscompares++; $display("FAIL push_pop_drain %0d got %h exp %h", i, got, exp_id); end
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 3; i++) do_aw(8'h90 + 8'(i), 1);
      for (int i = 3; i < 9; i++) begin
         do_aw(8'h90 + 8'(i), 1);
         send_w(1'b1, got);
         exp_id = exp_q.pop_front();
         vectors++;
         if (got !== exp_id) begin miscompares++; $display("FAIL wrap %0d got %h exp %h", i, got, exp_id); end
      end
      for (int i = 0; i < 3; i++) begin
         send_w(1'b1, got);
         exp_id = exp_q.pop_front();
         vectors++;
         if (got !== exp_id) begin miscompares++; $display("FAIL wrap_drain %0d got %h exp %h", i, got, exp_id); end
      end
      @(negedge per_clk);
      vectors++;
      if (outstanding !== 3'd0) begin miscompares++; $display("FAIL wrap_outstanding got %0d exp 0", outstanding); end
      tick();
   endtask

   task automatic test_bypass();
      s_awid = 8'h5A; s_awvalid = 1'b1; s_wvalid = 1'b1; s_wlast = 1'b1;
      b_awid = 8'h5A; b_awvalid = 1'b1; b_wvalid = 1'b1; b_wlast = 1'b1;
      exp_q.push_back(8'h5A);
      @(negedge per_clk);
      exp_id = exp_q.pop_front();
      vectors++;
      if (m_wvalid !== 1'b1 || m_wid !== exp_id) begin miscompares++; $display("FAIL bypass got vld=%b wid=%h exp 1/%h", m_wvalid, m_wid, exp_id); end
      vectors++;
      if (b_m_wvalid !== 1'b0 || b_awready !== 1'b1) begin miscompares++; $display("FAIL nobypass got wvld=%b ardy=%b exp 0/1", b_m_wvalid, b_awready); end
      tick();
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_wlast = 1'b0;
      b_awvalid = 1'b0;
      @(negedge per_clk);
      vectors++;
      if (outstanding !== 3'd0) begin miscompares++; $display("FAIL bypass_no_push got %0d exp 0", outstanding); end
      vectors++;
      if (b_m_wvalid !== 1'b1 || b_m_wid !== 8'h5A || b_outstanding !== 3'd1) begin
         miscompares++; $display("FAIL nobypass_next got vld=%b wid=%h out=%0d exp 1/5a/1", b_m_wvalid, b_m_wid, b_outstanding);
      end
      tick();
      b_wvalid = 1'b0; b_wlast = 1'b0;
      @(negedge per_clk);
      vectors++;
      if (b_outstanding !== 3'd0) begin miscompares++; $display("FAIL nobypass_pop got %0d exp 0", b_outstanding); end
      tick();
      // Multi-beat bypass: the ID must stay available for the second beat.
      s_awid = 8'h6B; s_awvalid = 1'b1; s_wvalid = 1'b1; s_wlast = 1'b0;
      @(negedge per_clk);
      vectors++;
      if (m_wvalid !== 1'b1 || m_wid !== 8'h6B) begin miscompares++; $display("FAIL bypass_multi got vld=%b wid=%h exp 1/6b", m_wvalid, m_wid); end
      tick();
      s_awvalid = 1'b0; s_wlast = 1'b1;
      @(negedge per_clk);
      vectors++;
      if (outstanding !== 3'd1 || m_wvalid !== 1'b1 || m_wid !== 8'h6B) begin
         miscompares++; $display("FAIL bypass_multi_tail got out=%0d vld=%b wid=%h exp 1/1/6b", outstanding, m_wvalid, m_wid);
      end
      tick();
      s_wvalid = 1'b0; s_wlast = 1'b0;
      @(negedge per_clk);
      vectors++;
      if (outstanding !== 3'd0) begin miscompares++; $display("FAIL bypass_multi_pop got %0d exp 0", outstanding); end
      tick();
   endtask

   task automatic test_long_burst();
      do_aw(8'h77, 17);
      for (int i = 0; i < 15; i++) begin
         send_w(1'b0, got);
         exp_id = exp_q.pop_front();
         vectors++;
         if (got !== exp_id) begin miscompares++; $display("FAIL long_wid %0d got %h exp %h", i, got, exp_id); end
      end
      @(negedge per_clk);
      vectors++;
      if (err_burst !== 1'b0) begin miscompares++; $display("FAIL long_err_early got %b exp 0", err_burst); end
      tick();
      send_w(1'b0, got);
      exp_id = exp_q.pop_front();
      @(negedge per_clk);
      vectors++;
      if (err_burst !== 1'b1) begin miscompares++; $display("FAIL long_err_set got %b exp 1", err_burst); end
      tick();
      send_w(1'b1, got);
      exp_id = exp_q.pop_front();
      vectors++;
      if (got !== exp_id) begin miscompares++; $display("FAIL long_last_wid got %h exp %h", got, exp_id); end
      @(negedge per_clk);
      vectors++;
      if (err_burst !== 1'b1 || outstanding !== 3'd0) begin
         miscompares++; $display("FAIL long_sticky got err=%b out=%0d exp 1/0", err_burst, outstanding);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      do_aw(8'hC1, 2);
      do_aw(8'hC2, 1);
      do_aw(8'hC3, 1);
      send_w(1'b0, got);
      exp_id = exp_q.pop_front();
      vectors++;
      if (got !== exp_id) begin miscompares++; $display("FAIL rstmid_wid got %h exp %h", got, exp_id); end
      for (int i = 0; i < 3; i++) begin
         b_awid = 8'hD0 + 8'(i); b_awvalid = 1'b1;
         tick();
      end
      b_awvalid = 1'b0;
      @(negedge per_clk);
      vectors++;
      if (outstanding !== 3'd3 || b_outstanding !== 3'd3) begin
         miscompares++; $display("FAIL rstmid_pre got %0d/%0d exp 3/3", outstanding, b_outstanding);
      end
      tick();
      per_rst = 1'b1;
      s_wvalid = 1'b1; b_wvalid = 1'b1;
      tick();
      @(negedge per_clk);
      vectors++;
      if (outstanding !== 3'd0 || b_outstanding !== 3'd0 || err_burst !== 1'b0) begin
         miscompares++; $display("FAIL rstmid_state got out=%0d/%0d err=%b exp 0/0/0", outstanding, b_outstanding, err_burst);
      end
      vectors++;
      if (m_wvalid !== 1'b0 || b_m_wvalid !== 1'b0) begin
         miscompares++; $display("FAIL rstmid_wvalid got %b/%b exp 0/0", m_wvalid, b_m_wvalid);
      end
      per_rst = 1'b0;
      tick();
      s_wvalid = 1'b0; b_wvalid = 1'b0;
      exp_q.delete();
      tick();
   endtask

   // ---------------- main sequence / report ----------------
   initial begin
      vectors = 0;
      miscompares = 0;
      per_rst = 1'b1;
      s_awid = '0; s_awvalid = 1'b0; s_wvalid = 1'b0; s_wlast = 1'b0;
      b_awid = '0; b_awvalid = 1'b0; b_wvalid = 1'b0; b_wlast = 1'b0;
      m_awready = 1'b1; m_wready = 1'b1;

      test_reset();
      test_in_order();
      test_backpressure();
      test_full();
      test_push_pop();
      test_wrap();
      test_bypass();
      test_long_burst();
      test_reset_mid();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
